dispatch_credit: RTL and testbench
==================================

DISPATCH_CREDIT -- requirements
Module: dispatch_credit

Interface
REQ-001 Parameter NUM_FU, default 3: number of reservation-station channels; fu code k (1..NUM_FU) selects channel k-1, code 0 means no FU (ROB slot only).
REQ-002 Parameter PREG_COUNT, default 128: physical registers; PREG_W = clog2(PREG_COUNT).
REQ-003 Parameter RS_DEPTH, default 8: entries per reservation station, which is also the initial credit per channel.
REQ-004 Parameter NUM_WB, default 3: writeback ports that mark a preg ready.
REQ-005 clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 valid_in  in  1  rename stage offers an instruction.
REQ-008 data_in  in  rename_data  renamed instruction (fu, pd_new, ps1, ps2, Opcode).
REQ-009 ready_in  out  1  dispatch accepts data_in this cycle.
REQ-010 rob_full  in  1  ROB cannot allocate.
REQ-011 rob_index_in  in  5  ROB tag for the instruction allocated this cycle.
REQ-012 rob_alloc  out  1  one-cycle pulse: ROB entry consumed.
REQ-013 flush  in  1  mispredict squash.
REQ-014 wb_valid  in  NUM_WB  writeback strobes.
REQ-015 wb_preg  in  NUM_WB x PREG_W  written pregs.
REQ-016 credit_ret  in  NUM_FU  one RS entry freed (issue or squash) per channel.
REQ-017 disp_valid  out  NUM_FU  one-hot-or-zero write enable into RS k.
REQ-018 disp_data  out  rs_data  buffered instruction plus rob tag and ps1_rdy/ps2_rdy.

Function
REQ-019 The block SHALL hold one instruction in a skid register (buf_valid, buf_data).
REQ-020 buf_fire SHALL equal buf_valid && !rob_full && !flush && (fu==0 || credit[fu-1] != 0).
REQ-021 ready_in SHALL equal !flush && (!buf_valid || buf_fire); valid_in && ready_in loads the buffer next cycle.
REQ-022 The minimum latency from acceptance to disp_valid or rob_alloc SHALL be 1 cycle; full throughput SHALL be 1 per cycle.
REQ-023 On buf_fire, rob_alloc SHALL pulse, and disp_valid[fu-1] SHALL pulse when fu != 0, both combinationally from the buffer, with disp_data.rob_tag = rob_index_in.
REQ-024 Each credit counter SHALL be clog2(RS_DEPTH+1) bits wide: decremented on dispatch to its channel, incremented on credit_ret, and held when both occur in the same cycle.
REQ-025 A credit_ret arriving with the counter at RS_DEPTH SHALL be an error, checked by an assertion; the counter saturates.
REQ-026 A preg ready table of PREG_COUNT bits SHALL be kept; preg 0 reads ready at all times.
REQ-027 On buf_fire, pd_new SHALL be cleared when pd_new != 0 and Opcode is neither 0100011 (store) nor 1100011 (branch).
REQ-028 Each wb_valid[i] SHALL set bit wb_preg[i]; any number of ports may fire in one cycle.
REQ-029 If a clear and a set hit the same preg in one cycle, the clear SHALL win.
REQ-030 ps1_rdy/ps2_rdy SHALL equal the table bit OR a same-cycle matching writeback (bypass).
REQ-031 flush SHALL drop the buffered instruction and block acceptance for that cycle; the table and credits SHALL be left unchanged, because RSs return squashed credits via credit_ret.
REQ-032 While stalled, buf_data SHALL be held stable, and disp_valid and rob_alloc SHALL be 0.

Reset
REQ-033 Reset SHALL set buf_valid=0, every credit to RS_DEPTH, and every table bit to 1.
REQ-034 During and after reset: ready_in=1 on the first cycle after reset deasserts, and disp_valid=0, rob_alloc=0.
REQ-035 Reset asserted mid-stall SHALL discard the buffered instruction without dispatching it.

Structure
REQ-036 rename_data, rs_data, the opcode constants (store, branch) and the fu code enumeration SHALL live in the shared package.
REQ-037 The ready table with its writeback ports and bypass SHALL be one sub-module, preg_ready_table.

Verification
REQ-038 ALU add pd_new=5 with ps1 busy and wb_preg=ps1 in the dispatch cycle -> disp_valid=001, ps1_rdy=1; table[5]=0 next cycle.
REQ-039 Nine back-to-back fu=1 instructions with no credit_ret -> eight dispatches, then the ninth stalls with ready_in=0; one credit_ret -> it dispatches on the next cycle.
REQ-040 Simultaneous dispatch to channel 2 and credit_ret[2] -> credit unchanged.
REQ-041 Store with pd_new=9 -> disp_valid=100 and table[9] unchanged; fu=0 -> rob_alloc=1 and disp_valid=000.
REQ-042 rob_full held 3 cycles with the buffer full -> data held, no pulses; flush on the 2nd cycle -> buffer empty, nothing dispatched.
REQ-043 wb to pd=12 in the same cycle as a dispatch clearing 12 -> table[12]=0.

Source files
------------

// File: rtl/dispatch_credit_pkg.sv
// Shared types and constants for the dispatch stage: renamed-instruction and
// reservation-station payloads, fu codes and the opcodes that never write a destination.
package dispatch_credit_pkg;

    localparam int unsigned NUM_FU_DEF     = 3;
    localparam int unsigned PREG_COUNT_DEF = 128;
    localparam int unsigned RS_DEPTH_DEF   = 8;
    localparam int unsigned NUM_WB_DEF     = 3;
    localparam int unsigned PREG_W         = $clog2(PREG_COUNT_DEF);
    localparam int unsigned ROB_W          = 5;
    localparam int unsigned FU_W           = 2;
    localparam int unsigned OP_W           = 7;

    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [FU_W-1:0] {
        FU_NONE = 2'd0,
        FU_ALU  = 2'd1,
        FU_MUL  = 2'd2,
        FU_LSU  = 2'd3
    } fu_e;

    typedef struct packed {
        fu_e              fu;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [OP_W-1:0]   opcode;
    } rename_data;

    typedef struct packed {
        rename_data       inst;
        logic [ROB_W-1:0] rob_tag;
        logic             ps1_rdy;
        logic             ps2_rdy;
    } rs_data;

    // Stores and branches carry no destination even if pd_new is nonzero.
    function automatic logic writes_dest(input rename_data d);
        return (d.pd_new != '0) && (d.opcode != OP_STORE) && (d.opcode != OP_BRANCH);
    endfunction

endpackage

// File: rtl/dispatch_credit_if.sv
// Rename-to-dispatch bus: instruction handshake, ROB allocation, writeback
// strobes, credit returns and the reservation-station write port.
interface dispatch_credit_if #(
    parameter int unsigned NUM_FU = dispatch_credit_pkg::NUM_FU_DEF,
    parameter int unsigned NUM_WB = dispatch_credit_pkg::NUM_WB_DEF
) ();
    import dispatch_credit_pkg::*;

    logic                         valid_in;
    rename_data                   data_in;
    logic                         ready_in;
    logic                         rob_full;
    logic [ROB_W-1:0]             rob_index_in;
    logic                         rob_alloc;
    logic                         flush;
    logic [NUM_WB-1:0]            wb_valid;
    logic [NUM_WB-1:0][PREG_W-1:0] wb_preg;
    logic [NUM_FU-1:0]            credit_ret;
    logic [NUM_FU-1:0]            disp_valid;
    rs_data                       disp_data;

    modport master (
        output valid_in, data_in, rob_full, rob_index_in, flush, wb_valid, wb_preg, credit_ret,
        input  ready_in, rob_alloc, disp_valid, disp_data
    );

    modport slave (
        input  valid_in, data_in, rob_full, rob_index_in, flush, wb_valid, wb_preg, credit_ret,
        output ready_in, rob_alloc, disp_valid, disp_data
    );

endinterface

// File: rtl/dispatch_credit_preg_ready_table.sv
// Physical-register ready bits: writebacks set, dispatch clears (clear wins),
// and source reads see same-cycle writebacks through a bypass.
module preg_ready_table
    import dispatch_credit_pkg::*;
#(
    parameter int unsigned PREG_COUNT = PREG_COUNT_DEF,
    parameter int unsigned NUM_WB     = NUM_WB_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB-1:0][PREG_W-1:0] wb_preg,
    input  logic                          clr_en,
    input  logic [PREG_W-1:0]             clr_preg,
    input  logic [PREG_W-1:0]             ps1,
    input  logic [PREG_W-1:0]             ps2,
    output logic                          ps1_rdy_c,
    output logic                          ps2_rdy_c
);

    logic [PREG_COUNT-1:0] ready_q;
    logic                  bypass1;
    logic                  bypass2;

    always_comb begin
        bypass1 = 1'b0;
        bypass2 = 1'b0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && (wb_preg[i] == ps1)) bypass1 = 1'b1;
            if (wb_valid[i] && (wb_preg[i] == ps2)) bypass2 = 1'b1;
        end
    end

    assign ps1_rdy_c = (ps1 == '0) || ready_q[ps1] || bypass1;
    assign ps2_rdy_c = (ps2 == '0) || ready_q[ps2] || bypass2;

    // The clear is the last write in the block so it overrides any same-cycle set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= '1;
        end else begin
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i]) ready_q[wb_preg[i]] <= 1'b1;
            end
            if (clr_en) ready_q[clr_preg] <= 1'b0;
        end
    end

endmodule

// File: rtl/dispatch_credit.sv
// Dispatch stage: one-entry skid buffer that releases an instruction to its
// reservation station when the ROB and that station's credit counter allow it.
module dispatch_credit
    import dispatch_credit_pkg::*;
#(
    parameter int unsigned NUM_FU     = NUM_FU_DEF,
    parameter int unsigned PREG_COUNT = PREG_COUNT_DEF,
    parameter int unsigned RS_DEPTH   = RS_DEPTH_DEF,
    parameter int unsigned NUM_WB     = NUM_WB_DEF
) (
    input logic               clk,
    input logic               reset,
    dispatch_credit_if.slave  bus
);

    localparam int unsigned       CRED_W   = $clog2(RS_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RS_DEPTH);

    logic              buf_valid;
    rename_data        buf_data;
    logic [CRED_W-1:0] credit [NUM_FU];
    logic              has_credit;
    logic              buf_fire;
    logic [NUM_FU-1:0] disp_hit;
    logic              ps1_rdy;
    logic              ps2_rdy;

    always_comb begin
        has_credit = (buf_data.fu == FU_NONE);
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if ((32'(buf_data.fu) == k + 1) && (credit[k] != '0)) has_credit = 1'b1;
        end
    end

    // Reset gates the fire so a stalled entry is discarded, never dispatched.
    assign buf_fire     = buf_valid && !reset && !bus.rob_full && !bus.flush && has_credit;
    assign bus.ready_in = !bus.flush && (!buf_valid || buf_fire);

    always_comb begin
        disp_hit = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            disp_hit[k] = buf_fire && (32'(buf_data.fu) == k + 1);
        end
    end

    assign bus.rob_alloc  = buf_fire;
    assign bus.disp_valid = disp_hit;
    assign bus.disp_data  = '{inst: buf_data, rob_tag: bus.rob_index_in,
                              ps1_rdy: ps1_rdy, ps2_rdy: ps2_rdy};

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (bus.flush) begin
            buf_valid <= 1'b0;
        end else if (bus.ready_in) begin
            buf_valid <= bus.valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.valid_in && bus.ready_in) buf_data <= bus.data_in;
    end

    // Dispatch consumes a credit, credit_ret refunds one; both together cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_FU; k++) credit[k] <= CRED_MAX;
        end else begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                assert (!(bus.credit_ret[k] && !disp_hit[k] && (credit[k] == CRED_MAX)))
                    else $error("credit return overflow on channel %0d", k);
                if (bus.credit_ret[k] && !disp_hit[k]) begin
                    if (credit[k] != CRED_MAX) credit[k] <= credit[k] + CRED_W'(1);
                end else if (disp_hit[k] && !bus.credit_ret[k]) begin
                    credit[k] <= credit[k] - CRED_W'(1);
                end
            end
        end
    end

    preg_ready_table #(
        .PREG_COUNT (PREG_COUNT),
        .NUM_WB     (NUM_WB)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (bus.wb_valid),
        .wb_preg   (bus.wb_preg),
        .clr_en    (buf_fire && writes_dest(buf_data)),
        .clr_preg  (buf_data.pd_new),
        .ps1       (buf_data.ps1),
        .ps2       (buf_data.ps2),
        .ps1_rdy_c (ps1_rdy),
        .ps2_rdy_c (ps2_rdy)
    );

endmodule

// File: tb/tb_dispatch_credit.sv
// Bench for dispatch_credit: directed scenarios then random traffic, all
// compared against a queue/array reference model of the dispatch rules.
module tb_dispatch_credit;
    import dispatch_credit_pkg::*;

    localparam int unsigned NFU   = 3;
    localparam int unsigned NWB   = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NPREG = 128;
    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rob_idx;
    int         checks = 0;
    int         errors = 0;

    bit         mtab [NPREG];
    int         mcred [NFU];
    rename_data mq [$];

    always #5 clk = ~clk;

    dispatch_credit_if #(.NUM_FU(NFU), .NUM_WB(NWB)) bus ();

    dispatch_credit #(
        .NUM_FU(NFU), .PREG_COUNT(NPREG), .RS_DEPTH(DEPTH), .NUM_WB(NWB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rename_data mk(input int fu, input int pd, input int s1, input int s2,
                                      input logic [6:0] op);
        rename_data d;
        d.fu     = fu_e'(FU_W'(fu));
        d.pd_new = PREG_W'(pd);
        d.ps1    = PREG_W'(s1);
        d.ps2    = PREG_W'(s2);
        d.opcode = op;
        return d;
    endfunction

    function automatic bit model_rdy(input logic [PREG_W-1:0] p);
        bit r = (p == '0) || mtab[p];
        for (int i = 0; i < int'(NWB); i++)
            if (bus.wb_valid[i] && bus.wb_preg[i] == p) r = 1'b1;
        return r;
    endfunction

    task automatic idle();
        bus.valid_in   = 1'b0;
        bus.data_in    = '0;
        bus.rob_full   = 1'b0;
        bus.flush      = 1'b0;
        bus.wb_valid   = '0;
        bus.wb_preg    = '0;
        bus.credit_ret = '0;
    endtask

    task automatic send(input rename_data d);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
    endtask

    // Compare this cycle's outputs against the model, then advance the model state.
    task automatic eval();
        rename_data        h;
        bit                fire;
        bit                exp_rdy;
        logic [NFU-1:0]    ed;
        @(negedge clk);
        if (reset) begin
            chk("rst_rob_alloc", 64'(bus.rob_alloc), 64'(0));
            chk("rst_disp_valid", 64'(bus.disp_valid), 64'(0));
            mq.delete();
            foreach (mcred[k]) mcred[k] = DEPTH;
            foreach (mtab[p]) mtab[p] = 1'b1;
        end else begin
            h    = (mq.size() != 0) ? mq[0] : '0;
            fire = (mq.size() != 0) && !bus.rob_full && !bus.flush &&
                   (h.fu == FU_NONE || (int'(h.fu) <= int'(NFU) && mcred[int'(h.fu) - 1] > 0));
            exp_rdy = !bus.flush && ((mq.size() == 0) || fire);
            ed = '0;
            if (fire && h.fu != FU_NONE) ed[int'(h.fu) - 1] = 1'b1;
            chk("ready_in", 64'(bus.ready_in), 64'(exp_rdy));
            chk("rob_alloc", 64'(bus.rob_alloc), 64'(fire));
            chk("disp_valid", 64'(bus.disp_valid), 64'(ed));
            if (fire) begin
                chk("disp_inst", 64'(bus.disp_data.inst), 64'(h));
                chk("rob_tag", 64'(bus.disp_data.rob_tag), 64'(rob_idx));
                chk("ps1_rdy", 64'(bus.disp_data.ps1_rdy), 64'(model_rdy(h.ps1)));
                chk("ps2_rdy", 64'(bus.disp_data.ps2_rdy), 64'(model_rdy(h.ps2)));
            end
            for (int i = 0; i < int'(NWB); i++)
                if (bus.wb_valid[i]) mtab[bus.wb_preg[i]] = 1'b1;
            if (fire && h.pd_new != 0 && h.opcode != OP_STORE && h.opcode != OP_BRANCH)
                mtab[h.pd_new] = 1'b0;
            for (int k = 0; k < int'(NFU); k++) begin
                mcred[k] = mcred[k] + int'(bus.credit_ret[k]) - int'(ed[k]);
                if (mcred[k] > int'(DEPTH)) mcred[k] = DEPTH;
            end
            if (bus.flush) mq.delete();
            else begin
                if (fire) void'(mq.pop_front());
                if (exp_rdy && bus.valid_in) mq.push_back(bus.data_in);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        rob_idx          = rob_idx + 5'd1;
        bus.rob_index_in = rob_idx;
    endtask

    task automatic ret(input int k, input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            bus.credit_ret[k] = 1'b1;
            eval();
            adv();
        end
        idle();
    endtask

    // Offer exp+1 instructions to one channel: exp dispatch, the last stalls until a credit returns.
    task automatic probe_credit(input int fu, input int exp);
        int cnt = 0;
        for (int i = 0; i <= exp; i++) begin
            send(mk(fu, 0, 0, 0, OP_ALU));
            eval();
            cnt += int'(bus.disp_valid[fu - 1]);
            adv();
        end
        idle();
        eval();
        cnt += int'(bus.disp_valid[fu - 1]);
        chk("probe_count", 64'(cnt), 64'(exp));
        chk("probe_stall_ready", 64'(bus.ready_in), 64'(0));
        chk("probe_stall_disp", 64'(bus.disp_valid), 64'(0));
        adv();
        bus.credit_ret[fu - 1] = 1'b1;
        eval();
        adv();
        idle();
        eval();
        chk("probe_release", 64'(bus.disp_valid), 64'(1 << (fu - 1)));
        adv();
        ret(fu - 1, DEPTH);
    endtask

    initial begin
        logic [6:0] ops [5];
        rename_data x;
        ops = '{OP_ALU, OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD};
        rob_idx = 5'd3;
        bus.rob_index_in = rob_idx;
        idle();
        reset = 1'b1;
        eval(); adv();
        eval(); adv();
        reset = 1'b0;
        eval();
        chk("post_reset_ready", 64'(bus.ready_in), 64'(1));
        adv();

        // ALU add with a busy source woken by a same-cycle writeback.
        send(mk(1, 20, 0, 0, OP_ALU)); eval(); adv();
        send(mk(1, 5, 20, 0, OP_ALU)); eval(); adv();
        idle();
        bus.wb_valid[0] = 1'b1;
        bus.wb_preg[0]  = 7'd20;
        eval();
        chk("alu_disp", 64'(bus.disp_valid), 64'(3'b001));
        chk("alu_bypass", 64'(bus.disp_data.ps1_rdy), 64'(1));
        adv();
        idle();
        send(mk(1, 0, 5, 0, OP_ALU)); eval(); adv();
        idle(); eval();
        chk("pd5_cleared", 64'(bus.disp_data.ps1_rdy), 64'(0));
        adv();
        ret(0, 3);

        probe_credit(1, DEPTH);

        // Dispatch and credit return on the same channel in one cycle.
        send(mk(3, 40, 0, 0, OP_ALU)); eval(); adv();
        send(mk(3, 41, 0, 0, OP_ALU)); eval(); adv();
        idle();
        bus.credit_ret[2] = 1'b1;
        eval();
        chk("simul_disp", 64'(bus.disp_valid), 64'(3'b100));
        adv();
        idle();
        probe_credit(3, DEPTH - 1);

        // Store leaves its pd ready; fu 0 only takes a ROB slot.
        send(mk(3, 9, 0, 0, OP_STORE)); eval(); adv();
        send(mk(0, 30, 0, 0, OP_IMM)); eval();
        chk("store_disp", 64'(bus.disp_valid), 64'(3'b100));
        adv();
        send(mk(1, 0, 9, 30, OP_ALU)); eval();
        chk("fu0_alloc", 64'(bus.rob_alloc), 64'(1));
        chk("fu0_disp", 64'(bus.disp_valid), 64'(0));
        adv();
        idle();
        bus.credit_ret[2] = 1'b1;
        eval();
        chk("store_pd_ready", 64'(bus.disp_data.ps1_rdy), 64'(1));
        chk("fu0_pd_cleared", 64'(bus.disp_data.ps2_rdy), 64'(0));
        adv();
        ret(0, 1);

        // ROB stall holds the entry; a flush mid-stall drops it.
        x = mk(2, 50, 1, 2, OP_ALU);
        send(x); eval(); adv();
        send(mk(2, 51, 3, 4, OP_ALU));
        bus.rob_full = 1'b1;
        eval();
        chk("stall_alloc", 64'(bus.rob_alloc), 64'(0));
        chk("stall_ready", 64'(bus.ready_in), 64'(0));
        chk("stall_hold1", 64'(bus.disp_data.inst), 64'(x));
        adv();
        bus.flush = 1'b1;
        eval();
        chk("flush_disp", 64'(bus.disp_valid), 64'(0));
        chk("stall_hold2", 64'(bus.disp_data.inst), 64'(x));
        adv();
        idle();
        bus.rob_full = 1'b1;
        eval();
        chk("flush_empty_ready", 64'(bus.ready_in), 64'(1));
        adv();
        idle(); eval();
        chk("flush_no_alloc", 64'(bus.rob_alloc), 64'(0));
        adv();

        // Writeback and dispatch clear hitting the same preg: the clear wins.
        send(mk(1, 12, 0, 0, OP_ALU)); eval(); adv();
        idle();
        bus.wb_valid[1] = 1'b1;
        bus.wb_preg[1]  = 7'd12;
        eval(); adv();
        idle();
        send(mk(1, 0, 12, 0, OP_ALU)); eval(); adv();
        idle(); eval();
        chk("clear_wins", 64'(bus.disp_data.ps1_rdy), 64'(0));
        adv();
        ret(0, 2);

        // Reset during a stall discards the buffered entry.
        send(mk(2, 60, 0, 0, OP_ALU));
        bus.rob_full = 1'b1;
        eval(); adv();
        bus.valid_in = 1'b0;
        eval(); adv();
        idle();
        reset = 1'b1;
        eval(); adv();
        reset = 1'b0;
        eval();
        chk("rst_stall_alloc", 64'(bus.rob_alloc), 64'(0));
        chk("rst_stall_ready", 64'(bus.ready_in), 64'(1));
        adv();

        for (int c = 0; c < 600; c++) begin
            bus.valid_in = ($urandom_range(0, 9) < 7);
            bus.data_in  = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                              ops[$urandom_range(0, 4)]);
            bus.rob_full = ($urandom_range(0, 9) < 2);
            bus.flush    = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < int'(NWB); i++) begin
                bus.wb_valid[i] = ($urandom_range(0, 2) == 0);
                bus.wb_preg[i]  = PREG_W'($urandom_range(0, 15));
            end
            for (int k = 0; k < int'(NFU); k++)
                bus.credit_ret[k] = (mcred[k] < int'(DEPTH)) && ($urandom_range(0, 2) == 0);
            eval();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
